// File: rtl/nibble_serial_adder_ctrl.sv
// Serial W-bit add/subtract through one shared 4-bit ripple adder.
// One nibble per clock, LSB first, with valid/ready on request and result.
module full_adder_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [4:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < 4; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout = c[4];
    end
endmodule

module nibble_serial_adder_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    input  logic                 op,
    input  logic                 cin,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [4*NIBBLES-1:0] result,
    output logic                 cout,
    output logic                 ovf,
    output logic                 busy
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [W-1:0]  a_q, b_q;
    logic          carry_q;
    logic [IW-1:0] idx_q;
    logic [W-1:0]  result_q;
    logic          cout_q, ovf_q, res_valid_q;

    logic          accept, step, last, release_res;
    logic [IW+1:0] sh;
    logic [W-1:0]  a_sh, b_sh, nib_mask, sum_w;
    logic [3:0]    nib_sum;
    logic          nib_cout;

    assign last = (idx_q == IW'(NIBBLES - 1));

    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        step        = 1'b0;
        release_res = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last) state_d = DONE;
            end
            DONE: begin
                if (res_ready) begin
                    release_res = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Nibble select by shifting keeps every index in range for any NIBBLES.
    assign sh       = {idx_q, 2'b00};
    assign a_sh     = a_q >> sh;
    assign b_sh     = b_q >> sh;
    assign nib_mask = W'(4'hF) << sh;
    assign sum_w    = W'(nib_sum) << sh;

    full_adder_4bit u_fa (
        .a    (a_sh[3:0]),
        .b    (b_sh[3:0]),
        .cin  (carry_q),
        .sum  (nib_sum),
        .cout (nib_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            result_q    <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            if (accept) begin
                a_q      <= a;
                b_q      <= op ? ~b : b;
                carry_q  <= op | cin;
                idx_q    <= '0;
                result_q <= '0;
                cout_q   <= 1'b0;
            end
            if (step) begin
                result_q <= (result_q & ~nib_mask) | sum_w;
                carry_q  <= nib_cout;
                idx_q    <= idx_q + IW'(1);
                if (last) begin
                    cout_q      <= nib_cout;
                    ovf_q       <= (a_q[W-1] == b_q[W-1]) &&
                                   (nib_sum[3] != a_q[W-1]);
                    res_valid_q <= 1'b1;
                end
            end
            if (release_res) res_valid_q <= 1'b0;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q == RUN);
    assign res_valid = res_valid_q;
    assign result    = result_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Randomized scoreboard bench for nibble_serial_adder_ctrl (NIBBLES=4).
// Expected results come from plain integer arithmetic on the operands.
module tb_nibble_serial_adder_ctrl;
    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         op = 1'b0;
    logic         cin = 1'b0;
    logic         res_valid;
    logic         res_ready = 1'b1;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;
    logic         busy;

    nibble_serial_adder_ctrl #(.NIBBLES(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .cin       (cin),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .result    (result),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] r;
        logic         c;
        logic         v;
    } exp_t;

    exp_t q[$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, expv);
    endtask

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic o, input logic ci);
        exp_t e;
        int ux, uy, sx, sy, u, s;
        ux = int'(x);
        uy = int'(y);
        sx = (ux >= 32768) ? ux - 65536 : ux;
        sy = (uy >= 32768) ? uy - 65536 : uy;
        if (o) begin
            u   = ux - uy;
            s   = sx - sy;
            e.c = (ux >= uy);
        end else begin
            u   = ux + uy + int'(ci);
            s   = sx + sy + int'(ci);
            e.c = (u >= 65536);
        end
        e.r = W'(u);
        e.v = (s > 32767) || (s < -32768);
        return e;
    endfunction

    exp_t me;
    always @(negedge clk) begin
        if (!rst && res_valid && res_ready) begin
            if (q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_result: got %h expected none", result);
            end else begin
                me = q.pop_front();
                chk("result", 32'(result), 32'(me.r));
                chk("cout", 32'(cout), 32'(me.c));
                chk("ovf", 32'(ovf), 32'(me.v));
            end
        end
    end

    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic o, input logic ci,
                         input bit mid_change, input bit hold);
        int cyc;
        logic [W-1:0] held;
        @(negedge clk);
        cyc = 0;
        while (!req_ready && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        if (!req_ready) begin
            n_checks++;
            $display("FAIL req_ready_timeout: got 0 expected 1");
            return;
        end
        a = x;
        b = y;
        op = o;
        cin = ci;
        req_valid = 1'b1;
        @(posedge clk);
        q.push_back(model(x, y, o, ci));
        #1;
        req_valid = 1'b0;
        if (hold) res_ready = 1'b0;
        chk("busy_in_run", 32'(busy), 32'd1);
        chk("req_ready_in_run", 32'(req_ready), 32'd0);
        cyc = 0;
        while (!res_valid && cyc < 20) begin
            if (mid_change && cyc == 1) begin
                a   = W'($urandom);
                b   = W'($urandom);
                op  = ~op;
                cin = ~cin;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("latency", 32'(cyc), 32'(N));
        if (hold) begin
            held = result;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                chk("hold_result", 32'(result), 32'(held));
                chk("hold_req_ready", 32'(req_ready), 32'd0);
                chk("hold_valid", 32'(res_valid), 32'd1);
            end
            @(posedge clk);
            #1;
            res_ready = 1'b1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        issue(16'h1234, 16'h4321, 1'b0, 1'b0, 0, 0);
        issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 0);
        issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, 0);
        issue(16'h0005, 16'h0007, 1'b1, 1'b0, 0, 0);
        issue(16'h8000, 16'h0001, 1'b1, 1'b1, 0, 0);
        issue(16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 0, 0);
        issue(16'h0000, 16'h0000, 1'b1, 1'b0, 0, 0);
        issue(16'hABCD, 16'h1357, 1'b0, 1'b1, 1, 1);

        @(negedge clk);
        a = 16'h1234;
        b = 16'h1111;
        op = 1'b0;
        cin = 1'b0;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrun_rst_ready", 32'(req_ready), 32'd1);
        chk("midrun_rst_valid", 32'(res_valid), 32'd0);
        chk("midrun_rst_result", 32'(result), 32'd0);
        chk("midrun_rst_busy", 32'(busy), 32'd0);
        issue(16'h0001, 16'h0001, 1'b0, 1'b0, 0, 0);

        for (int i = 0; i < 40; i++) begin
            issue(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), ($urandom_range(0, 3) == 0));
        end

        repeat (4) @(posedge clk);
        #1;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
